// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller for the 5-stage core.
//  - Per-stage stall/flush, load-use bubble, interrupt-detect strobe.
//  - Redirect PC for exceptions (EXC_VECTOR) and exception return (epc).
//  - Privileged control registers: status, pre_status, int_mask, exp_code, epc.
// Ports:
//  clk, reset (sync, active-high)
//  if_busy, mem_busy, ld_hazard          : hazard / bus-wait inputs
//  mem_en, mem_pc, mem_exp_code,
//  mem_ctrl_op, mem_cr_addr,
//  mem_cr_wr_data                        : EX/MEM register contents (commit point)
//  cr_rd_addr / cr_rd_data               : combinational control-register read
//  irq                                   : level-sensitive interrupt requests
//  *_stall, *_flush, new_pc, int_detect  : pipeline control outputs
//  exe_mode, int_en                      : current status bits
// Build option: PIPE_CTRL_IRQ_SYNC_EN adds a 2-flop synchronizer ahead of irq_q.
module pipe_ctrl #(
  parameter int                     WORD_ADDR_W = 30,
  parameter int                     IRQ_CH      = 8,
  parameter logic [WORD_ADDR_W-1:0] EXC_VECTOR  = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   if_busy,
  input  logic                   mem_busy,
  input  logic                   ld_hazard,
  input  logic                   mem_en,
  input  logic [WORD_ADDR_W-1:0] mem_pc,
  input  logic [2:0]             mem_exp_code,
  input  logic [1:0]             mem_ctrl_op,
  input  logic [2:0]             mem_cr_addr,
  input  logic [31:0]            mem_cr_wr_data,
  input  logic [2:0]             cr_rd_addr,
  input  logic [IRQ_CH-1:0]      irq,
  output logic [31:0]            cr_rd_data,
  output logic                   if_stall,
  output logic                   id_stall,
  output logic                   ex_stall,
  output logic                   mem_stall,
  output logic                   if_flush,
  output logic                   id_flush,
  output logic                   ex_flush,
  output logic                   mem_flush,
  output logic [WORD_ADDR_W-1:0] new_pc,
  output logic                   int_detect,
  output logic                   exe_mode,
  output logic                   int_en
);

  typedef enum logic {RUN, EXC_FLUSH} state_e;
  localparam logic [1:0] OP_WRCR = 2'd1;
  localparam logic [1:0] OP_EXRT = 2'd2;

  state_e                 state_q, state_d;
  logic                   exe_mode_q, int_en_q, pre_exe_mode_q, pre_int_en_q;
  logic [IRQ_CH-1:0]      int_mask_q, irq_q;
  logic [2:0]             exp_code_q;
  logic [WORD_ADDR_W-1:0] epc_q;

  logic stall, commit, take_exc, take_ret, do_wrcr;

  assign stall    = if_busy | mem_busy;
  // Only RUN may commit; the flush cycle scrubs wrong-path entries instead.
  assign commit   = mem_en & ~stall & (state_q == RUN);
  assign take_exc = commit & (mem_exp_code != 3'd0);
  assign take_ret = commit & ~take_exc & (mem_ctrl_op == OP_EXRT);
  assign do_wrcr  = commit & ~take_exc & (mem_ctrl_op == OP_WRCR);

  assign exe_mode = exe_mode_q;
  assign int_en   = int_en_q;

  always_comb begin
    state_d    = state_q;
    if_stall   = 1'b0;
    id_stall   = 1'b0;
    ex_stall   = 1'b0;
    mem_stall  = 1'b0;
    if_flush   = 1'b0;
    id_flush   = 1'b0;
    ex_flush   = 1'b0;
    mem_flush  = 1'b0;
    new_pc     = '0;
    int_detect = 1'b0;
    if (!reset) begin
      if_stall  = stall | ld_hazard;
      id_stall  = stall;
      ex_stall  = stall;
      mem_stall = stall;
      if (state_q == RUN) begin
        id_flush   = ld_hazard & ~stall;
        int_detect = int_en_q & (|(irq_q & ~int_mask_q)) & ~stall;
        if (take_exc || take_ret) begin
          if_flush  = 1'b1;
          id_flush  = 1'b1;
          ex_flush  = 1'b1;
          mem_flush = 1'b1;
          new_pc    = take_exc ? EXC_VECTOR : epc_q;
          state_d   = EXC_FLUSH;
        end
      end else if (!stall) begin
        // Fetch already redirected; clear the three entries behind it.
        id_flush  = 1'b1;
        ex_flush  = 1'b1;
        mem_flush = 1'b1;
        state_d   = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      exe_mode_q     <= 1'b0;
      int_en_q       <= 1'b0;
      pre_exe_mode_q <= 1'b0;
      pre_int_en_q   <= 1'b0;
      int_mask_q     <= '1;
      exp_code_q     <= '0;
      epc_q          <= '0;
    end else begin
      state_q <= state_d;
      if (take_exc) begin
        epc_q          <= mem_pc;
        exp_code_q     <= mem_exp_code;
        pre_exe_mode_q <= exe_mode_q;
        pre_int_en_q   <= int_en_q;
        exe_mode_q     <= 1'b0;
        int_en_q       <= 1'b0;
      end else if (take_ret) begin
        exe_mode_q <= pre_exe_mode_q;
        int_en_q   <= pre_int_en_q;
      end else if (do_wrcr) begin
        case (mem_cr_addr)
          3'd0: {exe_mode_q, int_en_q}         <= mem_cr_wr_data[1:0];
          3'd1: {pre_exe_mode_q, pre_int_en_q} <= mem_cr_wr_data[1:0];
          3'd2: int_mask_q <= mem_cr_wr_data[IRQ_CH-1:0];
          3'd3: exp_code_q <= mem_cr_wr_data[2:0];
          3'd4: epc_q      <= mem_cr_wr_data[WORD_ADDR_W+1:2];
          default: ;
        endcase
      end
    end
  end

`ifdef PIPE_CTRL_IRQ_SYNC_EN
  logic [IRQ_CH-1:0] irq_s1_q, irq_s2_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_s1_q <= '0;
      irq_s2_q <= '0;
      irq_q    <= '0;
    end else begin
      irq_s1_q <= irq;
      irq_s2_q <= irq_s1_q;
      irq_q    <= irq_s2_q;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) irq_q <= '0;
    else       irq_q <= irq;
  end
`endif

  always_comb begin
    cr_rd_data = '0;
    case (cr_rd_addr)
      3'd0: cr_rd_data[1:0]             = {exe_mode_q, int_en_q};
      3'd1: cr_rd_data[1:0]             = {pre_exe_mode_q, pre_int_en_q};
      3'd2: cr_rd_data[IRQ_CH-1:0]      = int_mask_q;
      3'd3: cr_rd_data[2:0]             = exp_code_q;
      3'd4: cr_rd_data[WORD_ADDR_W+1:0] = {epc_q, 2'b00};
      default: ;
    endcase
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage core. Generates per-stage stall/flush, the interrupt-detect strobe consumed by the ID/EX→EX/MEM register, and the redirect PC for exceptions and exception-return. Owns the privileged control registers: status, pre-status, interrupt mask, exception code and EPC. Exceptions are committed from the EX/MEM pipeline register outputs.

Parameters:
WORD_ADDR_W, 30, width of word addresses (PC, EPC, vector)
IRQ_CH, 8, number of interrupt request lines
EXC_VECTOR, 30'h0000_0000, word address of the exception handler

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
if_busy  in  1  IF bus access not complete
mem_busy  in  1  MEM bus access not complete
ld_hazard  in  1  load-use hazard from ID
mem_en  in  1  EX/MEM entry valid
mem_pc  in  WORD_ADDR_W  PC of EX/MEM instruction
mem_exp_code  in  3  exception code of EX/MEM instruction (0 = none, 1 = ext int, 2 = undef, 3 = overflow, 4 = misalign, 5 = trap, 6 = privilege)
mem_ctrl_op  in  2  0 = NOP, 1 = WRCR, 2 = EXRT
mem_cr_addr  in  3  control register address for WRCR
mem_cr_wr_data  in  32  WRCR data
cr_rd_addr  in  3  control register read address
irq  in  IRQ_CH  level-sensitive interrupt requests
cr_rd_data  out  32  combinational control register read
if_stall, id_stall, ex_stall, mem_stall  out  1 each  stage stalls
if_flush, id_flush, ex_flush, mem_flush  out  1 each  stage flushes
new_pc  out  WORD_ADDR_W  redirect target (valid when if_flush = 1)
int_detect  out  1  interrupt injection into EX
exe_mode  out  1  0 = kernel, 1 = user
int_en  out  1  global interrupt enable

Behaviour:
- Reset: synchronous, active-high. State RUN, exe_mode 0, int_en 0, pre_exe_mode 0, pre_int_en 0, int_mask all 1, exp_code 0, epc 0, irq pipeline 0. Stall, flush, int_detect and new_pc outputs are 0 while reset is high. A reset mid-redirect abandons the redirect.
- Stall: stall = if_busy | mem_busy.
  - id_stall = ex_stall = mem_stall = stall.
  - if_stall = stall | ld_hazard.
- Load-use bubble: id_flush = ld_hazard & ~stall.
- Control register map (cr_rd_data is zero-extended):
  - 0 status {exe_mode, int_en}
  - 1 pre_status
  - 2 int_mask[IRQ_CH-1:0]
  - 3 exp_code
  - 4 epc, read as {epc, 2'b00}
  - 5–7 read 0
- Commit condition: commit = mem_en & ~stall. Priority when commit = 1:
  1. mem_exp_code != 0:
     - epc ← mem_pc; exp_code ← mem_exp_code.
     - pre_status ← status; int_en ← 0; exe_mode ← 0.
     - All four flushes asserted this cycle; new_pc = EXC_VECTOR.
     - State → EXC_FLUSH.
  2. mem_ctrl_op = EXRT:
     - status ← pre_status.
     - All flushes asserted; new_pc = epc.
     - State → EXC_FLUSH.
  3. mem_ctrl_op = WRCR: write mem_cr_addr. Writes to 3 (exp_code) are allowed. Writes to 4 load mem_cr_wr_data[31:2]. No flush.
- EXC_FLUSH: lasts 1 cycle.
  - if_flush = 0.
  - id_flush = ex_flush = mem_flush = 1, scrubbing wrong-path entries.
  - No commit and no int_detect.
  - Returns to RUN. If stall is high, remains in EXC_FLUSH with flushes deasserted.
- Flushes are never asserted while stall = 1. A pending exception waits for stall to drop.
- int_detect = int_en & |(irq_q & ~int_mask) & ~stall & (state == RUN).
  - irq_q is irq registered once, giving 1 cycle detect latency.
  - The EX stage turns this into exp_code 1, which commits later through priority 1.
- The WRCR of int_en and the exception-clear of int_en cannot coincide, because priority applies.

Optional Feature:
PIPE_CTRL_IRQ_SYNC_EN: when defined, irq passes through a 2-flop synchronizer before irq_q, giving 3 cycle latency from irq to int_detect. Synchronizer flops reset to 0. When undefined, irq_q is a single register with 1 cycle latency.

Test Plan:
- reset held 2 cycles with irq = 8'hFF → int_en 0, int_mask 8'hFF, all stalls/flushes 0, cr_rd_data(addr 2) = 32'hFF.
- mem_busy = 1 for 3 cycles with mem_exp_code = 3, mem_pc = 30'h40 → no flush during busy; cycle after busy drops: all flushes = 1, new_pc = 0, epc read = 32'h100, exp_code = 3; next cycle: if_flush 0, others 1.
- WRCR addr 2 data 0, then WRCR addr 0 data 1; irq[3] = 1 → int_detect = 1 one cycle after irq (3 cycles with the macro defined).
- Status {0,1}, trap at mem_pc = 30'h10 → status {0,0}; later EXRT → new_pc = 30'h10, status restored to {0,1}.
- ld_hazard = 1 with no stall → if_stall 1, id_flush 1, ex_stall 0; with mem_busy also 1 → id_flush 0.
- Exception plus EXRT in the same entry (mem_exp_code = 6, ctrl_op EXRT) → exception wins: new_pc = EXC_VECTOR, exp_code = 6.
